// File: rtl/sap_serial_loader.sv
// Purpose: 8N1 UART receiver that writes each received byte into the SAP core RAM through its manual programming port.
// Latency: WR rises 1 cycle after the stop-bit mid-sample, plus a 2-cycle rx synchronizer.
// Backpressure: none; the write sequence finishes inside the stop bit, so full line rate is absorbed.
module sap_serial_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 4,
    parameter int MEM_DEPTH    = 16,
    parameter int WR_PULSE     = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              rx,
    input  logic              load_req,
    output logic [ADDR_W-1:0] mar_dip,
    output logic [7:0]        ram_dip,
    output logic              WR,
    output logic              prog_run,
    output logic              load_done,
    output logic              frame_err,
    output logic [ADDR_W:0]   byte_count
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(WR_PULSE + 1);
    localparam logic [TW-1:0]   HALF_T  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]   FULL_T  = TW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0]   PLAST_T = PW'(WR_PULSE - 1);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, SETUP, PULSE, HOLD, DONE
    } state_t;

    state_t            state, state_n;
    logic              rx_meta, rx_sync;
    logic [TW-1:0]     timer, timer_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [7:0]        shift, shift_n;
    logic [PW-1:0]     pulse_cnt, pulse_cnt_n;
    logic [ADDR_W:0]   count_n;
    logic [ADDR_W-1:0] mar_n;
    logic [7:0]        ram_n;
    logic              wr_n, run_n, done_n, ferr_n;

    // Synchronizer resets to the idle line level so reset release cannot fake a start bit.
    always_ff @(posedge clock) begin
        if (!clear) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            pulse_cnt  <= '0;
            byte_count <= '0;
            mar_dip    <= '0;
            ram_dip    <= '0;
            WR         <= 1'b0;
            prog_run   <= 1'b0;
            load_done  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            bit_idx    <= bit_idx_n;
            shift      <= shift_n;
            pulse_cnt  <= pulse_cnt_n;
            byte_count <= count_n;
            mar_dip    <= mar_n;
            ram_dip    <= ram_n;
            WR         <= wr_n;
            prog_run   <= run_n;
            load_done  <= done_n;
            frame_err  <= ferr_n;
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer + 1'b1;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        pulse_cnt_n = pulse_cnt;
        count_n     = byte_count;
        mar_n       = mar_dip;
        ram_n       = ram_dip;
        wr_n        = 1'b0;
        run_n       = prog_run;
        done_n      = load_done;
        ferr_n      = frame_err;

        case (state)
            IDLE: begin
                timer_n = '0;
                if (!rx_sync) state_n = START;
            end
            START: begin
                if (timer == HALF_T) begin
                    timer_n   = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == FULL_T) begin
                    timer_n   = '0;
                    shift_n   = {rx_sync, shift[7:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (timer == FULL_T) begin
                    timer_n = '0;
                    if (rx_sync) begin
                        mar_n   = byte_count[ADDR_W-1:0];
                        ram_n   = shift;
                        state_n = SETUP;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            SETUP: begin
                wr_n        = 1'b1;
                pulse_cnt_n = '0;
                state_n     = PULSE;
            end
            PULSE: begin
                wr_n        = 1'b1;
                pulse_cnt_n = pulse_cnt + 1'b1;
                if (pulse_cnt == PLAST_T) begin
                    wr_n    = 1'b0;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                count_n = byte_count + 1'b1;
                if (count_n == DEPTH_C) begin
                    run_n   = 1'b1;
                    done_n  = 1'b1;
                    mar_n   = '0;
                    ram_n   = '0;
                    state_n = DONE;
                end else begin
                    state_n = IDLE;
                end
            end
            DONE: begin
                timer_n = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Re-arm overrides everything, including the HOLD to DONE step.
        if (load_req) begin
            state_n = IDLE;
            timer_n = '0;
            count_n = '0;
            mar_n   = '0;
            ram_n   = '0;
            wr_n    = 1'b0;
            run_n   = 1'b0;
            done_n  = 1'b0;
            ferr_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_sap_serial_loader.sv
// Bench for sap_serial_loader: directed UART traffic, a byte-level session model and a per-cycle WR watcher.
module tb_sap_serial_loader;

    localparam int CPB    = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int WRP    = 2;

    logic              clock = 1'b0;
    logic              clear = 1'b0;
    logic              rx = 1'b1;
    logic              load_req = 1'b0;
    logic [ADDR_W-1:0] mar_dip;
    logic [7:0]        ram_dip;
    logic              WR;
    logic              prog_run;
    logic              load_done;
    logic              frame_err;
    logic [ADDR_W:0]   byte_count;

    sap_serial_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W),
        .MEM_DEPTH   (DEPTH),
        .WR_PULSE    (WRP)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .rx        (rx),
        .load_req  (load_req),
        .mar_dip   (mar_dip),
        .ram_dip   (ram_dip),
        .WR        (WR),
        .prog_run  (prog_run),
        .load_done (load_done),
        .frame_err (frame_err),
        .byte_count(byte_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    int   errors = 0;
    int   checks = 0;
    wr_t  exp_q[$];
    logic [4:0] m_count = '0;
    logic m_done = 1'b0;
    logic m_ferr = 1'b0;
    int   n_writes = 0;
    logic [3:0] last_addr = '0;
    logic [7:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Session model: what a whole received byte must do to the RAM and the status flags.
    task automatic model_byte(input logic [7:0] d, input logic stop);
        wr_t e;
        if (m_done) return;
        if (!stop) begin
            m_ferr = 1'b1;
            return;
        end
        e.addr = m_count[3:0];
        e.data = d;
        exp_q.push_back(e);
        m_count = m_count + 5'd1;
        if (m_count == 5'(DEPTH)) m_done = 1'b1;
    endtask

    task automatic model_rearm();
        m_count = '0;
        m_done  = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_byte_count"}, 32'(byte_count), 32'(m_count));
        chk({tag, "_load_done"},  32'(load_done),  32'(m_done));
        chk({tag, "_prog_run"},   32'(prog_run),   32'(m_done));
        chk({tag, "_frame_err"},  32'(frame_err),  32'(m_ferr));
        if (m_done) begin
            chk({tag, "_mar_done"}, 32'(mar_dip), 32'(0));
            chk({tag, "_ram_done"}, 32'(ram_dip), 32'(0));
        end
    endtask

    // Timing invariant for stimulus tasks: entered and left 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        idle(CPB);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        model_byte(d, stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        idle(1);
        load_req = 1'b0;
        model_rearm();
    endtask

    // WR watcher: every pulse must match the next modelled write, be WRP cycles wide,
    // and keep address/data stable from one cycle before to one cycle after.
    logic       prev_wr = 1'b0;
    logic [3:0] prev_mar = '0, cap_mar = '0;
    logic [7:0] prev_ram = '0, cap_ram = '0;
    int         wr_len = 0;

    always @(negedge clock) begin
        wr_t e;
        if (!clear) begin
            prev_wr  = 1'b0;
            prev_mar = '0;
            prev_ram = '0;
            wr_len   = 0;
        end else begin
            if (WR && !prev_wr) begin
                chk("pre_addr_stable", 32'(mar_dip), 32'(prev_mar));
                chk("pre_data_stable", 32'(ram_dip), 32'(prev_ram));
                cap_mar   = mar_dip;
                cap_ram   = ram_dip;
                wr_len    = 1;
                n_writes++;
                last_addr = mar_dip;
                last_data = ram_dip;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", mar_dip, ram_dip);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mar_dip), 32'(e.addr));
                    chk("wr_data", 32'(ram_dip), 32'(e.data));
                end
            end else if (WR) begin
                wr_len++;
                chk("mid_addr_stable", 32'(mar_dip), 32'(cap_mar));
                chk("mid_data_stable", 32'(ram_dip), 32'(cap_ram));
            end else if (prev_wr) begin
                chk("wr_width", 32'(wr_len), 32'(WRP));
                chk("post_addr_stable", 32'(mar_dip), 32'(cap_mar));
                chk("post_data_stable", 32'(ram_dip), 32'(cap_ram));
            end
            if (WR) chk("wr_in_prog_mode", 32'(prog_run), 32'(0));
            prev_wr  = WR;
            prev_mar = mar_dip;
            prev_ram = ram_dip;
        end
    end

    initial begin
        int w0;

        // Reset with the line idle.
        clear = 1'b0;
        idle(5);
        chk("rst_mar",        32'(mar_dip),    32'(0));
        chk("rst_ram",        32'(ram_dip),    32'(0));
        chk("rst_wr",         32'(WR),         32'(0));
        chk("rst_prog_run",   32'(prog_run),   32'(0));
        chk("rst_load_done",  32'(load_done),  32'(0));
        chk("rst_frame_err",  32'(frame_err),  32'(0));
        chk("rst_byte_count", 32'(byte_count), 32'(0));
        clear = 1'b1;
        idle(1000);
        chk("idle_no_writes", 32'(n_writes), 32'(0));
        check_status("idle");

        // Single byte.
        send_byte(8'hA5, 1'b1);
        idle(30);
        chk("a5_count_lit", 32'(byte_count), 32'(1));
        chk("a5_addr_lit",  32'(last_addr),  32'(0));
        chk("a5_data_lit",  32'(last_data),  32'(8'hA5));
        chk("a5_nwrites",   32'(n_writes),   32'(1));
        check_status("a5");

        // Full session back to back, then one byte that must be ignored.
        pulse_load_req();
        check_status("rearm1");
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b1);
        idle(30);
        chk("full_done_lit",  32'(load_done),  32'(1));
        chk("full_run_lit",   32'(prog_run),   32'(1));
        chk("full_count_lit", 32'(byte_count), 32'(16));
        chk("full_nwrites",   32'(n_writes),   32'(17));
        chk("full_last_data", 32'(last_data),  32'(8'h0F));
        check_status("full");
        send_byte(8'h99, 1'b1);
        idle(30);
        chk("done_ignore_nwrites", 32'(n_writes), 32'(17));
        check_status("done_ignore");

        // Framing error followed by a good byte.
        pulse_load_req();
        send_byte(8'h5A, 1'b0);
        idle(40);
        send_byte(8'h3C, 1'b1);
        idle(30);
        chk("ferr_lit",       32'(frame_err),  32'(1));
        chk("ferr_addr_lit",  32'(last_addr),  32'(0));
        chk("ferr_data_lit",  32'(last_data),  32'(8'h3C));
        chk("ferr_count_lit", 32'(byte_count), 32'(1));
        check_status("ferr");

        // Short low glitch must be rejected by the start-bit check.
        pulse_load_req();
        w0 = n_writes;
        rx = 1'b0;
        idle(8);
        rx = 1'b1;
        idle(40);
        chk("glitch_nwrites", 32'(n_writes),  32'(w0));
        chk("glitch_ferr",    32'(frame_err), 32'(0));
        check_status("glitch");

        // Reach DONE again, re-arm, and load one byte.
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i * 37 + 1), 1'b1);
        idle(30);
        check_status("full2");
        pulse_load_req();
        chk("rearm_run",  32'(prog_run),  32'(0));
        chk("rearm_done", 32'(load_done), 32'(0));
        send_byte(8'h77, 1'b1);
        idle(30);
        chk("s77_addr_lit",  32'(last_addr),  32'(0));
        chk("s77_data_lit",  32'(last_data),  32'(8'h77));
        chk("s77_count_lit", 32'(byte_count), 32'(1));
        check_status("s77");

        // Reset in the middle of the data bits.
        w0 = n_writes;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        clear = 1'b0;
        idle(3);
        rx = 1'b1;
        chk("midrst_count", 32'(byte_count), 32'(0));
        chk("midrst_wr",    32'(WR),         32'(0));
        chk("midrst_mar",   32'(mar_dip),    32'(0));
        chk("midrst_ram",   32'(ram_dip),    32'(0));
        clear = 1'b1;
        model_rearm();
        idle(300);
        chk("midrst_nwrites", 32'(n_writes), 32'(w0));
        check_status("midrst");

        chk("pending_writes", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sap_serial_loader.md
Name: sap_serial_loader

Overview:
- Serial program loader for the SAP core. Receives 8N1 UART bytes from a host and drives the core's manual programming interface: RAM address (mar_dip), RAM data (ram_dip), write strobe (WR) and prog_run.
- It is the initiator side of the interface that the RAM and MAR respond to, and replaces the DIP switches and push button.
- Byte k of a load session is written to RAM address k. After MEM_DEPTH bytes it releases the core into run mode.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Must be >= 8.
- ADDR_W, 4, RAM address width.
- MEM_DEPTH, 16, bytes per load session. Equals 2**ADDR_W.
- WR_PULSE, 2, WR high time in cycles. Requires WR_PULSE+2 < CLKS_PER_BIT/2.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- clear  in  1  synchronous, active-low reset.
- rx  in  1  UART serial input; idles high; asynchronous to clock.
- load_req  in  1  one-cycle pulse that re-arms a new load session.
- mar_dip  out  ADDR_W  RAM write address to the core.
- ram_dip  out  8  RAM write data to the core.
- WR  out  1  write strobe to the core, active high.
- prog_run  out  1  0 = programming mode (core uses the DIP path), 1 = run.
- load_done  out  1  high once MEM_DEPTH bytes are written; stays high until re-armed.
- frame_err  out  1  sticky; set on a bad stop bit; cleared by clear or load_req.
- byte_count  out  ADDR_W+1  number of bytes written in the current session.

Behaviour:
- Reset (clear=0 at a clock edge): all outputs 0, FSM in IDLE, bit timer 0. The core therefore starts in programming mode. A reset mid-byte or mid-write aborts it: no WR pulse completes, byte_count returns to 0.
- rx input: passed through a 2-flop synchronizer; the FSM uses only the synchronized value.
- FSM states: IDLE, START, DATA, STOP, SETUP, PULSE, HOLD, DONE.
- IDLE: a synchronized rx=0 enters START with the timer cleared.
- START: at timer = CLKS_PER_BIT/2-1, sample rx.
  - rx=0: go to DATA, timer cleared, bit index 0.
  - rx=1: glitch; return to IDLE.
- DATA: sample rx every CLKS_PER_BIT cycles (mid-bit), LSB first, into the shift register. After bit 7, go to STOP.
- STOP: sample at mid-bit.
  - rx=1: go to SETUP.
  - rx=0: set frame_err, discard the byte, go to IDLE. byte_count and mar_dip are unchanged.
- SETUP (1 cycle): mar_dip = byte_count[ADDR_W-1:0], ram_dip = received byte, WR=0.
- PULSE (WR_PULSE cycles): WR=1; mar_dip and ram_dip held stable.
- HOLD (1 cycle): WR=0, address and data still held. Then byte_count increments.
  - New byte_count = MEM_DEPTH: go to DONE.
  - Otherwise: go to IDLE.
- Write timing: the write sequence ends before the next start bit can be qualified, so no byte is lost at full line rate.
- DONE: prog_run=1, load_done=1, WR=0, mar_dip and ram_dip = 0.
  - rx traffic is ignored; no writes, frame_err unaffected.
- load_req=1 in any state except reset: at the next edge, byte_count=0, prog_run=0, load_done=0, frame_err=0, WR=0; go to IDLE. An in-flight byte is discarded.
- Simultaneous events: clear=0 has priority over load_req. A load_req in the same cycle as the HOLD→DONE transition wins; the session is re-armed.
- Address width: byte_count is ADDR_W+1 bits so that MEM_DEPTH is representable. mar_dip uses the low ADDR_W bits; no wrap occurs within a session.
- Latency: WR rises 1 cycle after the stop-bit mid-sample edge, plus the 2-cycle synchronizer delay on rx.

Test Plan (CLKS_PER_BIT=16, WR_PULSE=2):
- Reset, rx idle high: all outputs 0; no WR for 1000 cycles.
- Send 0xA5 → one WR pulse exactly 2 cycles wide with mar_dip=0, ram_dip=0xA5 stable from 1 cycle before to 1 cycle after the pulse; byte_count=1.
- Send 16 back-to-back bytes 0x00..0x0F → 16 writes with addr=data; then load_done=1 and prog_run=1. A 17th byte produces no WR.
- Send a byte with stop bit 0, then 0x3C → frame_err=1; the bad byte is not written; 0x3C is written to address 0.
- 8-cycle low glitch on rx (shorter than a bit) → START rejects it; no write, frame_err=0.
- In DONE, pulse load_req, then send 0x77 → prog_run=0, load_done=0, write to address 0. Assert clear mid-DATA → outputs 0 and the partial byte is not written.
